// File: rtl/sp3a_spi_target_regfile.sv
// SPI target for the SP3A controller frame: setup bits, address, group, WE, zero bit, data.
// Groups 0-2 are read/write configuration registers, group 3 reads back status_in.
module sp3a_spi_target_regfile #(
    parameter int unsigned SETUP_BITS     = 3,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned REGS_PER_GROUP = 16
) (
    input  logic                               spi_clk,
    input  logic                               reset,
    input  logic                               cs_b,
    input  logic                               pico,
    output logic                               poci,
    input  logic [REGS_PER_GROUP*DATA_W-1:0]   status_in,
    output logic [3*REGS_PER_GROUP*DATA_W-1:0] cfg_regs,
    output logic                               wr_strobe,
    output logic                               frame_err
);

    localparam int unsigned CfgW   = 3 * REGS_PER_GROUP * DATA_W;
    localparam int unsigned IdxW   = $clog2(CfgW);
    localparam int unsigned StIdxW = $clog2(REGS_PER_GROUP * DATA_W);
    localparam int unsigned CntMax = (DATA_W > 8) ? ((DATA_W > SETUP_BITS) ? DATA_W : SETUP_BITS)
                                                  : ((SETUP_BITS > 8) ? SETUP_BITS : 8);
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [3:0] {
        StIdle, StSkip, StAddr, StGroup, StWe, StZero, StWdata, StRdata, StDrain
    } state_e;

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q;
    logic [7:0]         addr_q;
    logic [1:0]         grp_q;
    logic               we_q;
    logic [DATA_W-2:0]  data_sr_q;
    logic [DATA_W-1:0]  out_sr_q;
    logic [CfgW-1:0]    cfg_q;
    logic               wr_strobe_q;
    logic               frame_err_q;

    logic [7:0]         rd_addr;
    logic [IdxW-1:0]    rd_idx;
    logic [StIdxW-1:0]  st_idx;
    logic [DATA_W-1:0]  rd_word;
    logic [IdxW-1:0]    wr_idx;
    logic               wr_ok;
    logic               last_data_bit;

    // Read word for the load on the zero-bit edge (current addr) or the burst reload (addr+1)
    always_comb begin
        rd_addr = (state_q == StZero) ? addr_q : addr_q + 8'd1;
        rd_idx  = IdxW'((32'(grp_q) * REGS_PER_GROUP + 32'(rd_addr)) * DATA_W);
        st_idx  = StIdxW'(32'(rd_addr) * DATA_W);
        wr_idx  = IdxW'((32'(grp_q) * REGS_PER_GROUP + 32'(addr_q)) * DATA_W);
        wr_ok   = (grp_q != 2'd3) && (32'(addr_q) < REGS_PER_GROUP);
        last_data_bit = (cnt_q == CntW'(DATA_W - 1));
        rd_word = '0;
        if (32'(rd_addr) < REGS_PER_GROUP) begin
            if (grp_q == 2'd3) begin
                rd_word = status_in[st_idx +: DATA_W];
            end else begin
                rd_word = cfg_q[rd_idx +: DATA_W];
            end
        end
    end

    // State register
    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; cs_b high always returns to idle
    always_comb begin
        state_d = state_q;
        if (cs_b) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = (SETUP_BITS > 1) ? StSkip : StAddr;
                StSkip:  if (cnt_q == CntW'(SETUP_BITS - 1)) state_d = StAddr;
                StAddr:  if (cnt_q == CntW'(7)) state_d = StGroup;
                StGroup: if (cnt_q == CntW'(1)) state_d = StWe;
                StWe:    state_d = StZero;
                StZero:  state_d = pico ? StDrain : (we_q ? StWdata : StRdata);
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath: bit counting, field shifting, register commits and read shifting
    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            grp_q       <= '0;
            we_q        <= 1'b0;
            data_sr_q   <= '0;
            out_sr_q    <= '0;
            cfg_q       <= '0;
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_strobe_q <= 1'b0;
            frame_err_q <= 1'b0;
            if (cs_b) begin
                // Partial word is dropped by clearing the count and shift register
                cnt_q     <= '0;
                data_sr_q <= '0;
            end else begin
                unique case (state_q)
                    StIdle: cnt_q <= (SETUP_BITS > 1) ? CntW'(1) : '0;
                    StSkip: begin
                        cnt_q <= (cnt_q == CntW'(SETUP_BITS - 1)) ? '0 : cnt_q + CntW'(1);
                    end
                    StAddr: begin
                        addr_q <= {addr_q[6:0], pico};
                        cnt_q  <= (cnt_q == CntW'(7)) ? '0 : cnt_q + CntW'(1);
                    end
                    StGroup: begin
                        grp_q <= {grp_q[0], pico};
                        cnt_q <= (cnt_q == CntW'(1)) ? '0 : cnt_q + CntW'(1);
                    end
                    StWe: we_q <= pico;
                    StZero: begin
                        cnt_q <= '0;
                        if (pico) begin
                            frame_err_q <= 1'b1;
                        end else if (!we_q) begin
                            out_sr_q <= rd_word;
                        end
                    end
                    StWdata: begin
                        data_sr_q <= {data_sr_q[DATA_W-3:0], pico};
                        if (last_data_bit) begin
                            cnt_q       <= '0;
                            wr_strobe_q <= 1'b1;
                            addr_q      <= addr_q + 8'd1;
                            if (wr_ok) cfg_q[wr_idx +: DATA_W] <= {data_sr_q, pico};
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StRdata: begin
                        if (last_data_bit) begin
                            cnt_q    <= '0;
                            addr_q   <= addr_q + 8'd1;
                            out_sr_q <= rd_word;
                        end else begin
                            cnt_q    <= cnt_q + CntW'(1);
                            out_sr_q <= {out_sr_q[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Outputs; poci only driven while shifting read data
    always_comb begin
        poci      = (state_q == StRdata) ? out_sr_q[DATA_W-1] : 1'b0;
        cfg_regs  = cfg_q;
        wr_strobe = wr_strobe_q;
        frame_err = frame_err_q;
    end

endmodule

// File: tb/tb_sp3a_spi_target_regfile.sv
// Bench for sp3a_spi_target_regfile: directed and random frames against a register-array model.
module tb_sp3a_spi_target_regfile;

    localparam int SETUP = 3;
    localparam int DW    = 32;
    localparam int RPG   = 16;

    logic              spi_clk;
    logic              reset;
    logic              cs_b;
    logic              pico;
    logic              poci;
    logic [RPG*DW-1:0] status_in;
    logic [3*RPG*DW-1:0] cfg_regs;
    logic              wr_strobe;
    logic              frame_err;

    sp3a_spi_target_regfile #(
        .SETUP_BITS    (SETUP),
        .DATA_W        (DW),
        .REGS_PER_GROUP(RPG)
    ) dut (
        .spi_clk  (spi_clk),
        .reset    (reset),
        .cs_b     (cs_b),
        .pico     (pico),
        .poci     (poci),
        .status_in(status_in),
        .cfg_regs (cfg_regs),
        .wr_strobe(wr_strobe),
        .frame_err(frame_err)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    int vectors = 0;
    int miscompares = 0;
    int strobe_seen = 0;
    int err_seen = 0;
    int strobe_exp = 0;
    int err_exp = 0;

    logic [31:0] model_cfg [48];
    logic [31:0] status_m [16];
    logic [31:0] tx [8];
    logic [31:0] rx [8];

    // Pulse counters; each 1-cycle pulse is seen at exactly one falling edge
    always @(negedge spi_clk) begin
        if (wr_strobe === 1'b1) strobe_seen++;
        if (frame_err === 1'b1) err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int g = 0; g < 3; g++) begin
            for (int k = 0; k < RPG; k++) begin
                check($sformatf("%s reg[%0d][%0d]", tag, g, k),
                      cfg_regs[(g*RPG+k)*DW +: DW], model_cfg[g*RPG+k]);
            end
        end
    endtask

    task automatic set_status();
        for (int k = 0; k < RPG; k++) status_in[k*DW +: DW] = status_m[k];
    endtask

    // Drive one bit for the next rising edge; poci is sampled first
    task automatic shift_bit(input logic b, output logic o);
        @(negedge spi_clk);
        o    = poci;
        cs_b = 1'b0;
        pico = b;
    endtask

    task automatic send_header(input logic [7:0] a, input logic [1:0] g, input logic w,
                               input logic z);
        logic o;
        for (int i = 0; i < SETUP; i++) shift_bit(1'($urandom), o);
        for (int i = 7; i >= 0; i--) shift_bit(a[i], o);
        shift_bit(g[1], o);
        shift_bit(g[0], o);
        shift_bit(w, o);
        shift_bit(z, o);
    endtask

    task automatic do_frame(input logic [7:0] a, input logic [1:0] g, input logic w,
                            input logic z, input int nwords, input int tail_bits);
        logic o;
        send_header(a, g, w, z);
        for (int k = 0; k < nwords; k++) begin
            for (int i = DW - 1; i >= 0; i--) begin
                shift_bit(tx[k][i], o);
                rx[k][i] = o;
            end
        end
        for (int i = 0; i < tail_bits; i++) shift_bit(1'($urandom), o);
        @(negedge spi_clk);
        cs_b = 1'b1;
        pico = 1'b0;
    endtask

    function automatic logic [31:0] exp_read(input logic [1:0] g, input logic [7:0] ad);
        if (int'(ad) >= RPG) return 32'h0;
        if (g == 2'd3) return status_m[ad[3:0]];
        return model_cfg[int'(g) * RPG + int'(ad)];
    endfunction

    // Apply the frame's effect to the model; reads are compared against rx
    task automatic model_frame(input string tag, input logic [7:0] a, input logic [1:0] g,
                               input logic w, input logic z, input int nwords);
        logic [7:0] ad;
        if (z) begin
            err_exp++;
            return;
        end
        for (int k = 0; k < nwords; k++) begin
            ad = a + 8'(k);
            if (w) begin
                strobe_exp++;
                if (int'(ad) < RPG && g != 2'd3) model_cfg[int'(g) * RPG + int'(ad)] = tx[k];
            end else begin
                check($sformatf("%s rd g%0d a%0d", tag, g, ad), rx[k], exp_read(g, ad));
            end
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] a, input logic [1:0] g,
                         input logic w, input logic z, input int nwords);
        do_frame(a, g, w, z, nwords, 0);
        model_frame(tag, a, g, w, z, nwords);
    endtask

    task automatic check_counts(input string tag);
        @(negedge spi_clk);
        check({tag, " wr_strobe count"}, 32'(strobe_seen), 32'(strobe_exp));
        check({tag, " frame_err count"}, 32'(err_seen), 32'(err_exp));
    endtask

    initial begin
        logic [7:0]  ra;
        logic [1:0]  rg;
        logic        rw;
        int          rn;
        logic        o;

        reset = 1'b0;
        cs_b  = 1'b1;
        pico  = 1'b0;
        for (int k = 0; k < 48; k++) model_cfg[k] = 32'h0;
        for (int k = 0; k < RPG; k++) status_m[k] = $urandom;
        status_m[2] = 32'hA5A5_0001;
        set_status();

        // Reset state
        #2 reset = 1'b1;
        #2;
        check("reset poci", 32'(poci), 32'h0);
        check("reset wr_strobe", 32'(wr_strobe), 32'h0);
        check("reset frame_err", 32'(frame_err), 32'h0);
        check_regs("reset");
        repeat (2) @(negedge spi_clk);
        reset = 1'b0;
        @(negedge spi_clk);

        // Single write then read back
        tx[0] = 32'hDEAD_BEEF;
        frame("wr1", 8'h05, 2'd1, 1'b1, 1'b0, 1);
        check_regs("wr1");
        check_counts("wr1");
        frame("rd1", 8'h05, 2'd1, 1'b0, 1'b0, 1);
        check("rd1 poci idle", 32'(poci), 32'h0);

        // Burst across the end of the group: second word dropped, two strobes
        tx[0] = 32'h1111_1111;
        tx[1] = 32'h2222_2222;
        frame("burst", 8'h0F, 2'd0, 1'b1, 1'b0, 2);
        check_regs("burst");
        check_counts("burst");

        // Zero bit set: error pulse, data ignored
        tx[0] = 32'hCAFE_F00D;
        frame("zerr", 8'h03, 2'd2, 1'b1, 1'b1, 1);
        check_regs("zerr");
        check_counts("zerr");

        // Abort after 20 data bits
        do_frame(8'h05, 2'd1, 1'b1, 1'b0, 0, 20);
        check_regs("abort");
        check_counts("abort");

        // Status group reads, and a write to it that must not stick
        frame("st rd", 8'h02, 2'd3, 1'b0, 1'b0, 1);
        check("st rd word", rx[0], 32'hA5A5_0001);
        tx[0] = 32'h0;
        frame("st wr", 8'h02, 2'd3, 1'b1, 1'b0, 1);
        frame("st rd2", 8'h02, 2'd3, 1'b0, 1'b0, 2);
        check_counts("status");

        // Random back-to-back frames, including out-of-range and wrapping addresses
        for (int n = 0; n < 24; n++) begin
            ra = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255))
                                             : 8'($urandom_range(0, 19));
            rg = 2'($urandom_range(0, 3));
            rw = 1'($urandom);
            rn = $urandom_range(1, 3);
            for (int k = 0; k < 8; k++) tx[k] = $urandom;
            frame($sformatf("rnd%0d", n), ra, rg, rw, 1'b0, rn);
        end
        check_regs("rnd");
        check_counts("rnd");

        // Reset in the middle of a write
        tx[0] = 32'h1234_5678;
        send_header(8'h01, 2'd0, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) shift_bit(1'($urandom), o);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 48; k++) model_cfg[k] = 32'h0;
        check("midrst poci", 32'(poci), 32'h0);
        check("midrst wr_strobe", 32'(wr_strobe), 32'h0);
        check("midrst frame_err", 32'(frame_err), 32'h0);
        check_regs("midrst");
        cs_b = 1'b1;
        repeat (2) @(negedge spi_clk);
        reset = 1'b0;
        @(negedge spi_clk);
        frame("post wr", 8'h01, 2'd0, 1'b1, 1'b0, 1);
        frame("post rd", 8'h01, 2'd0, 1'b0, 1'b0, 1);
        check("post rd word", rx[0], 32'h1234_5678);
        check_regs("post");
        check_counts("post");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
